// File: rtl/tl_source_shrinker_if.sv
// TileLink A/D channel bundle (TL-UL/TL-UH) shared by the host and device sides
// of the source shrinker; only the source width differs between the two sides.
`ifndef TL_SIZE_WIDTH
`define TL_SIZE_WIDTH 3
`endif

interface tl_source_shrinker_if #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 56,
  parameter int SourceWidth = 3,
  parameter int SinkWidth   = 1
);
  logic                       a_valid;
  logic                       a_ready;
  logic [2:0]                 a_opcode;
  logic [2:0]                 a_param;
  logic [`TL_SIZE_WIDTH-1:0]  a_size;
  logic [SourceWidth-1:0]     a_source;
  logic [AddrWidth-1:0]       a_address;
  logic [DataWidth/8-1:0]     a_mask;
  logic                       a_corrupt;
  logic [DataWidth-1:0]       a_data;

  logic                       d_valid;
  logic                       d_ready;
  logic [2:0]                 d_opcode;
  logic [1:0]                 d_param;
  logic [`TL_SIZE_WIDTH-1:0]  d_size;
  logic [SourceWidth-1:0]     d_source;
  logic [SinkWidth-1:0]       d_sink;
  logic                       d_denied;
  logic                       d_corrupt;
  logic [DataWidth-1:0]       d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_source_shrinker.sv
// Narrows wide host source IDs onto a small pool of device source slots and
// restores the original ID on D responses; A and D channels only.
`ifndef TL_SIZE_WIDTH
`define TL_SIZE_WIDTH 3
`endif

module tl_source_shrinker_chk #(
  parameter int N    = 2,
  parameter int SrcW = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            d_valid,
  input  logic [SrcW-1:0] d_source,
  input  logic [N-1:0]    busy
);
  // A D beat must always target a slot that is currently in flight.
  d_on_busy_slot: assert property (@(posedge clk_i) disable iff (rst_i)
    d_valid |-> busy[d_source]);
endmodule

module tl_source_shrinker #(
  parameter int DataWidth         = 64,
  parameter int AddrWidth         = 56,
  parameter int HostSourceWidth   = 3,
  parameter int DeviceSourceWidth = 1,
  parameter int SinkWidth         = 1,
  parameter int MaxSize           = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  tl_source_shrinker_if.slave    host,
  tl_source_shrinker_if.master   device
);
  localparam int N       = 2 ** DeviceSourceWidth;
  localparam int SzW     = `TL_SIZE_WIDTH;
  localparam int LgBytes = $clog2(DataWidth / 8);
  localparam int BeatW   = (MaxSize > LgBytes) ? (MaxSize - LgBytes + 1) : 1;

  if (DeviceSourceWidth > HostSourceWidth) begin : g_bad_width
    $fatal(1, "DeviceSourceWidth must not exceed HostSourceWidth");
  end

  typedef enum logic [0:0] {
    A_IDLE  = 1'b0,
    A_BURST = 1'b1
  } a_state_e;

  // Number of beats a message occupies; oversized requests are clamped to MaxSize.
  function automatic logic [BeatW-1:0] beats_of(input logic [SzW-1:0] size,
                                                input logic           has_data);
    logic [SzW-1:0] sz;
    sz = (size > SzW'(MaxSize)) ? SzW'(MaxSize) : size;
    if (has_data && (sz > SzW'(LgBytes))) begin
      beats_of = BeatW'(1) << (sz - SzW'(LgBytes));
    end else begin
      beats_of = BeatW'(1);
    end
  endfunction

  a_state_e                      a_state_r, a_state_n;
  logic [N-1:0]                  busy_r, busy_n;
  logic [HostSourceWidth-1:0]    orig_src_r [N];
  logic [DeviceSourceWidth-1:0]  a_slot_r, a_slot_n;
  logic [BeatW-1:0]              a_left_r, a_left_n;
  logic [BeatW-1:0]              d_left_r, d_left_n;

  logic [DeviceSourceWidth-1:0]  free_idx_s;
  logic                          any_free_s;
  logic                          a_inburst_s;
  logic                          a_gate_s;
  logic                          a_hs_s;
  logic                          alloc_s;
  logic                          d_hs_s;
  logic                          d_last_s;
  logic [BeatW-1:0]              a_beats_s;
  logic [BeatW-1:0]              d_beats_s;
  logic [N-1:0]                  busy_set_s;
  logic [N-1:0]                  busy_clr_s;
  logic [AddrWidth-1:0]          a_addr_s;
  logic [SinkWidth-1:0]          d_sink_s;

  // Lowest-index free slot, taken from the registered busy vector only.
  always_comb begin
    free_idx_s = {DeviceSourceWidth{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      free_idx_s = busy_r[i] ? free_idx_s : DeviceSourceWidth'(i);
    end
  end

  assign any_free_s  = |(~busy_r);
  assign a_inburst_s = (a_state_r == A_BURST);
  assign a_gate_s    = a_inburst_s | any_free_s;

  assign device.a_valid = host.a_valid & a_gate_s;
  assign host.a_ready   = device.a_ready & a_gate_s;
  assign a_hs_s         = host.a_valid & host.a_ready;
  assign alloc_s        = a_hs_s & ~a_inburst_s;

  assign a_addr_s          = host.a_address;
  assign device.a_address  = a_addr_s;
  assign device.a_source   = a_inburst_s ? a_slot_r : free_idx_s;
  assign device.a_opcode   = host.a_opcode;
  assign device.a_param    = host.a_param;
  assign device.a_size     = host.a_size;
  assign device.a_mask     = host.a_mask;
  assign device.a_corrupt  = host.a_corrupt;
  assign device.a_data     = host.a_data;

  assign host.d_valid    = device.d_valid;
  assign device.d_ready  = host.d_ready;
  assign d_hs_s          = device.d_valid & device.d_ready;

  assign d_sink_s        = device.d_sink;
  assign host.d_sink     = d_sink_s;
  assign host.d_source   = orig_src_r[device.d_source];
  assign host.d_opcode   = device.d_opcode;
  assign host.d_param    = device.d_param;
  assign host.d_size     = device.d_size;
  assign host.d_denied   = device.d_denied;
  assign host.d_corrupt  = device.d_corrupt;
  assign host.d_data     = device.d_data;

  assign a_beats_s = beats_of(host.a_size, (host.a_opcode < 3'd4));
  assign d_beats_s = beats_of(device.d_size, (device.d_opcode == 3'd1));

  // Burst tracking for both channels and the slot busy vector update.
  always_comb begin
    a_state_n  = a_state_r;
    a_slot_n   = a_slot_r;
    a_left_n   = a_left_r;
    d_left_n   = d_left_r;
    d_last_s   = 1'b0;
    busy_set_s = {N{1'b0}};
    busy_clr_s = {N{1'b0}};

    case (a_state_r)
      A_IDLE: begin
        if (a_hs_s) begin
          busy_set_s[free_idx_s] = 1'b1;
          if (a_beats_s > BeatW'(1)) begin
            a_state_n = A_BURST;
            a_slot_n  = free_idx_s;
            a_left_n  = a_beats_s - BeatW'(1);
          end else begin
            a_state_n = A_IDLE;
          end
        end else begin
          a_state_n = A_IDLE;
        end
      end
      A_BURST: begin
        if (a_hs_s) begin
          a_left_n = a_left_r - BeatW'(1);
          if (a_left_r == BeatW'(1)) begin
            a_state_n = A_IDLE;
          end else begin
            a_state_n = A_BURST;
          end
        end else begin
          a_state_n = A_BURST;
        end
      end
      default: begin
        a_state_n = A_IDLE;
        a_left_n  = BeatW'(0);
      end
    endcase

    if (d_hs_s) begin
      if (d_left_r == BeatW'(0)) begin
        if (d_beats_s == BeatW'(1)) begin
          d_last_s = 1'b1;
        end else begin
          d_left_n = d_beats_s - BeatW'(1);
        end
      end else begin
        d_left_n = d_left_r - BeatW'(1);
        d_last_s = (d_left_r == BeatW'(1));
      end
    end else begin
      d_left_n = d_left_r;
    end

    if (d_last_s) begin
      busy_clr_s[device.d_source] = 1'b1;
    end else begin
      busy_clr_s = {N{1'b0}};
    end

    // Set after clear so a same-index allocate wins over a free.
    busy_n = (busy_r & ~busy_clr_s) | busy_set_s;
  end

  // State registers; in-flight transactions are discarded by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_state_r <= A_IDLE;
      busy_r    <= {N{1'b0}};
      a_slot_r  <= {DeviceSourceWidth{1'b0}};
      a_left_r  <= BeatW'(0);
      d_left_r  <= BeatW'(0);
      for (int i = 0; i < N; i++) begin
        orig_src_r[i] <= {HostSourceWidth{1'b0}};
      end
    end else begin
      a_state_r <= a_state_n;
      busy_r    <= busy_n;
      a_slot_r  <= a_slot_n;
      a_left_r  <= a_left_n;
      d_left_r  <= d_left_n;
      if (alloc_s) begin
        orig_src_r[free_idx_s] <= host.a_source;
      end
    end
  end

  tl_source_shrinker_chk #(
    .N    (N),
    .SrcW (DeviceSourceWidth)
  ) u_chk (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .d_valid  (device.d_valid),
    .d_source (device.d_source),
    .busy     (busy_r)
  );
endmodule

// File: tb/tb_tl_source_shrinker.sv
// Directed bench for tl_source_shrinker: slot allocation, full-table stall,
// A and D bursts, same-cycle free/allocate and reset in the middle of a burst.
module tb_tl_source_shrinker;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_i = ~clk_i;

  tl_source_shrinker_if #(.DataWidth(64), .AddrWidth(56), .SourceWidth(3), .SinkWidth(1)) host_if ();
  tl_source_shrinker_if #(.DataWidth(64), .AddrWidth(56), .SourceWidth(1), .SinkWidth(1)) dev_if ();

  tl_source_shrinker #(
    .DataWidth(64), .AddrWidth(56), .HostSourceWidth(3),
    .DeviceSourceWidth(1), .SinkWidth(1), .MaxSize(6)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .host   (host_if),
    .device (dev_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] sz, input logic [2:0] src,
                         input logic [63:0] data);
    host_if.a_valid   = 1'b1;
    host_if.a_opcode  = op;
    host_if.a_param   = 3'd0;
    host_if.a_size    = sz;
    host_if.a_source  = src;
    host_if.a_address = 56'h0000_0000_0010_00 + {53'd0, src};
    host_if.a_mask    = 8'hFF;
    host_if.a_corrupt = 1'b0;
    host_if.a_data    = data;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] sz, input logic src,
                         input logic [63:0] data);
    dev_if.d_valid   = 1'b1;
    dev_if.d_opcode  = op;
    dev_if.d_param   = 2'd0;
    dev_if.d_size    = sz;
    dev_if.d_source  = src;
    dev_if.d_sink    = 1'b1;
    dev_if.d_denied  = 1'b0;
    dev_if.d_corrupt = 1'b0;
    dev_if.d_data    = data;
  endtask

  // Single-beat AccessAckData on a slot, checking the restored source.
  task automatic ack(input logic slot, input logic [2:0] exp_src, input string tag);
    drive_d(3'd1, 3'd3, slot, 64'hDD00_0000_0000_0000 | {63'd0, slot});
    #1;
    chk(tag, {61'd0, host_if.d_source}, {61'd0, exp_src});
    tick();
    dev_if.d_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] bdata;
    host_if.a_valid = 1'b0;
    drive_a(3'd4, 3'd3, 3'd0, 64'd0);
    host_if.a_valid = 1'b0;
    drive_d(3'd1, 3'd3, 1'b0, 64'd0);
    dev_if.d_valid  = 1'b0;
    dev_if.a_ready  = 1'b1;
    host_if.d_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("rst_busy", {62'd0, dut.busy_r}, 64'd0);
    chk("rst_inburst", {63'd0, dut.a_inburst_s}, 64'd0);
    chk("rst_dev_a_valid", {63'd0, dev_if.a_valid}, 64'd0);

    // Single Get from source 5 lands on slot 0
    drive_a(3'd4, 3'd3, 3'd5, 64'd0);
    #1;
    chk("get_dev_valid", {63'd0, dev_if.a_valid}, 64'd1);
    chk("get_dev_src", {63'd0, dev_if.a_source}, 64'd0);
    chk("get_host_ready", {63'd0, host_if.a_ready}, 64'd1);
    chk("get_addr", {8'd0, dev_if.a_address}, 64'h0000_0000_0000_1005);
    tick();
    host_if.a_valid = 1'b0;
    chk("get_busy", {62'd0, dut.busy_r}, 64'd1);
    drive_d(3'd1, 3'd3, 1'b0, 64'h1234_5678_9ABC_DEF0);
    #1;
    chk("ack_host_valid", {63'd0, host_if.d_valid}, 64'd1);
    chk("ack_host_src", {61'd0, host_if.d_source}, 64'd5);
    chk("ack_host_data", host_if.d_data, 64'h1234_5678_9ABC_DEF0);
    tick();
    dev_if.d_valid = 1'b0;
    chk("ack_busy", {62'd0, dut.busy_r}, 64'd0);

    // Table full, third request stalls until slot 0 frees (same-cycle free/alloc)
    drive_a(3'd4, 3'd3, 3'd2, 64'd0);
    #1;
    chk("full_src_a", {63'd0, dev_if.a_source}, 64'd0);
    tick();
    drive_a(3'd4, 3'd3, 3'd6, 64'd0);
    #1;
    chk("full_src_b", {63'd0, dev_if.a_source}, 64'd1);
    tick();
    chk("full_busy", {62'd0, dut.busy_r}, 64'd3);
    drive_a(3'd4, 3'd3, 3'd7, 64'd0);
    #1;
    chk("full_stall_ready", {63'd0, host_if.a_ready}, 64'd0);
    chk("full_stall_valid", {63'd0, dev_if.a_valid}, 64'd0);
    tick();
    chk("full_stall_ready2", {63'd0, host_if.a_ready}, 64'd0);
    drive_d(3'd1, 3'd3, 1'b0, 64'd0);
    #1;
    chk("full_free_src", {61'd0, host_if.d_source}, 64'd2);
    chk("same_cycle_ready", {63'd0, host_if.a_ready}, 64'd0);
    tick();
    dev_if.d_valid = 1'b0;
    #1;
    chk("next_cycle_ready", {63'd0, host_if.a_ready}, 64'd1);
    chk("next_cycle_src", {63'd0, dev_if.a_source}, 64'd0);
    tick();
    host_if.a_valid = 1'b0;
    chk("refill_busy", {62'd0, dut.busy_r}, 64'd3);
    ack(1'b1, 3'd6, "drain_src1");
    ack(1'b0, 3'd7, "drain_src0");
    chk("drain_busy", {62'd0, dut.busy_r}, 64'd0);

    // A burst on slot 0 while slot 1 is freed mid-burst
    drive_a(3'd4, 3'd3, 3'd1, 64'd0);
    tick();
    drive_a(3'd4, 3'd3, 3'd4, 64'd0);
    tick();
    host_if.a_valid = 1'b0;
    ack(1'b0, 3'd1, "pre_burst_src");
    chk("pre_burst_busy", {62'd0, dut.busy_r}, 64'd2);
    for (int b = 0; b < 8; b++) begin
      bdata = 64'hA5A5_0000_0000_0000 | 64'(b);
      drive_a(3'd0, 3'd6, 3'd3, bdata);
      dev_if.a_ready = 1'b0;
      if (b == 3) begin
        drive_d(3'd1, 3'd3, 1'b1, 64'd0);
      end
      #1;
      if (b == 3) begin
        chk("burst_d_src", {61'd0, host_if.d_source}, 64'd4);
      end
      chk($sformatf("burst_hold_ready%0d", b), {63'd0, host_if.a_ready}, 64'd0);
      chk($sformatf("burst_hold_valid%0d", b), {63'd0, dev_if.a_valid}, 64'd1);
      tick();
      dev_if.d_valid = 1'b0;
      dev_if.a_ready = 1'b1;
      #1;
      chk($sformatf("burst_src%0d", b), {63'd0, dev_if.a_source}, 64'd0);
      chk($sformatf("burst_data%0d", b), dev_if.a_data, bdata);
      chk($sformatf("burst_mask%0d", b), {56'd0, dev_if.a_mask}, 64'hFF);
      tick();
    end
    host_if.a_valid = 1'b0;
    chk("burst_end_inburst", {63'd0, dut.a_inburst_s}, 64'd0);
    chk("burst_end_busy", {62'd0, dut.busy_r}, 64'd1);
    drive_d(3'd0, 3'd6, 1'b0, 64'd0);
    #1;
    chk("put_ack_src", {61'd0, host_if.d_source}, 64'd3);
    tick();
    dev_if.d_valid = 1'b0;
    chk("put_ack_busy", {62'd0, dut.busy_r}, 64'd0);

    // D burst: 8 AccessAckData beats with host_d_ready stalls
    drive_a(3'd4, 3'd6, 3'd2, 64'd0);
    tick();
    host_if.a_valid = 1'b0;
    chk("dburst_get_inburst", {63'd0, dut.a_inburst_s}, 64'd0);
    for (int b = 0; b < 8; b++) begin
      bdata = 64'hBEEF_0000_0000_0000 | 64'(b);
      drive_d(3'd1, 3'd6, 1'b0, bdata);
      host_if.d_ready = 1'b0;
      #1;
      chk($sformatf("dburst_stall%0d", b), {63'd0, dev_if.d_ready}, 64'd0);
      tick();
      host_if.d_ready = 1'b1;
      #1;
      chk($sformatf("dburst_src%0d", b), {61'd0, host_if.d_source}, 64'd2);
      chk($sformatf("dburst_data%0d", b), host_if.d_data, bdata);
      tick();
      chk($sformatf("dburst_busy%0d", b), {62'd0, dut.busy_r}, (b == 7) ? 64'd0 : 64'd1);
    end
    dev_if.d_valid = 1'b0;

    // Reset on beat 4 of an 8-beat burst held on slot 1
    drive_a(3'd4, 3'd3, 3'd7, 64'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      drive_a(3'd0, 3'd6, 3'd6, 64'(b));
      #1;
      chk($sformatf("rburst_src%0d", b), {63'd0, dev_if.a_source}, 64'd1);
      tick();
    end
    drive_a(3'd0, 3'd6, 3'd6, 64'd4);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    host_if.a_valid = 1'b0;
    chk("mid_rst_busy", {62'd0, dut.busy_r}, 64'd0);
    chk("mid_rst_inburst", {63'd0, dut.a_inburst_s}, 64'd0);
    drive_a(3'd4, 3'd3, 3'd1, 64'd0);
    #1;
    chk("post_rst_src", {63'd0, dev_if.a_source}, 64'd0);
    tick();
    host_if.a_valid = 1'b0;
    chk("post_rst_busy", {62'd0, dut.busy_r}, 64'd1);
    ack(1'b0, 3'd1, "post_rst_ack_src");
    chk("post_rst_final_busy", {62'd0, dut.busy_r}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tl_source_shrinker.md
Name: tl_source_shrinker

Overview:
- Sits directly downstream of the TileLink data upsizer, whose widened device-side source field it narrows back down.
- Remaps wide host source IDs onto a small pool of device source IDs; each original ID is held in a slot table and restored on D responses.
- Scope: A and D channels only (TL-UL/TL-UH traffic). B/C/E are not supported.
- Stalls new A requests when every slot is in flight.

Parameters:
- DataWidth, 64, data bus width in bits (same on both sides).
- AddrWidth, 56, address width.
- HostSourceWidth, 3, source width on the host side.
- DeviceSourceWidth, 1, source width on the device side; slot count N = 2**DeviceSourceWidth; $fatal if greater than HostSourceWidth.
- SinkWidth, 1, D sink width (passed through).
- MaxSize, 6, log2 of max transfer bytes; max beats = 2**(MaxSize - log2(DataWidth/8)).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- host_a_valid/ready  in/out  1  host A handshake.
- host_a_opcode, param, size, source, address, mask, corrupt, data  in  3, 3, `TL_SIZE_WIDTH, HostSourceWidth, AddrWidth, DataWidth/8, 1, DataWidth  host A payload.
- device_a_valid/ready  out/in  1  device A handshake.
- device_a_{same fields}  out  as host, except source is DeviceSourceWidth.
- device_d_valid/ready  in/out  1  device D handshake.
- device_d_opcode, param, size, source, sink, denied, corrupt, data  in  3, 2, `TL_SIZE_WIDTH, DeviceSourceWidth, SinkWidth, 1, 1, DataWidth  device D payload.
- host_d_valid/ready  out/in  1  host D handshake.
- host_d_{same fields}  out  as device, except source is HostSourceWidth.

Behaviour:
- State: busy_q[N], orig_src_q[N][HostSourceWidth], a_inburst_q, a_slot_q, a_left_q (A beats remaining), d_left_q (D beats remaining).
- Beat count is 2**(size - log2(DataWidth/8)) when size exceeds the bus width, else 1.
  - A carries data for opcodes 0-3; D carries data for opcode 1 (AccessAckData).
  - Data-less messages count as 1 beat.
- Free slot: the lowest index i with busy_q[i] == 0. any_free = |~busy_q. Free status comes from registered busy_q only.
- A path:
  - First beat (a_inburst_q == 0): device_a_valid = host_a_valid & any_free; host_a_ready = device_a_ready & any_free; device_a_source = the free index.
  - Later beats (a_inburst_q == 1): source = a_slot_q; the path does not depend on any_free.
  - All other A fields pass through unchanged, with zero latency.
  - On a first-beat handshake: set busy_q[idx] and orig_src_q[idx] = host_a_source. If beats > 1, set a_inburst_q, a_slot_q = idx, a_left_q = beats - 1.
  - On each later handshake: decrement a_left_q; clear a_inburst_q when it reaches 1.
- D path:
  - Zero-latency pass-through: host_d_valid = device_d_valid; device_d_ready = host_d_ready.
  - host_d_source = orig_src_q[device_d_source]; all other fields are unchanged.
  - d_left_q tracks beats. On the last-beat handshake, clear busy_q[device_d_source].
- Simultaneous A allocate and D free in the same cycle: the freed slot becomes allocatable from the next cycle. If both target the same index (impossible by protocol), the allocate wins.
- Table full: A stalls with host_a_ready = 0, and device_a_valid = 0 on the first beat. Later beats of an in-progress burst are never stalled by a full table.
- host_a_ready and device_a_valid never depend combinationally on the ready/valid of the same side.
- Reset (including mid-operation): busy_q = 0, a_inburst_q = 0, a_left_q = 0, d_left_q = 0; orig_src_q is don't-care. In-flight transactions are discarded.
- Outputs after reset: device_a_valid = host_a_valid (any_free = 1); host_d_valid = device_d_valid.
- Assertion: a D beat whose device_d_source has busy_q == 0 is an error.

Test Plan:
- Single Get: size 3, source 5 -> device source 0, busy_q = 01. AccessAckData on source 0 -> host_d_source = 5, busy_q = 00 the next cycle.
- Table full: Gets from sources 2 then 6 take slots 0 and 1. A third A (source 7) is held with host_a_ready = 0 until the D for slot 0 completes, then issues one cycle later on slot 0.
- A burst: PutFullData, size 6 (8 beats), source 3, device_a_ready toggling -> all 8 beats carry source 0 and data/mask are unchanged. Meanwhile a D freeing slot 1 does not disturb the burst.
- D burst: Get, size 6 -> 8 AccessAckData beats all return host_d_source = original. The slot frees only after the 8th beat handshake; host_d_ready stalls are honoured.
- Same-cycle free/alloc: the D last beat frees slot 0 while a new A is waiting with the table full -> that A handshakes in the next cycle, not the same one.
- Reset mid-burst: assert rst_i on beat 4 of 8 -> busy_q = 0, a_inburst_q = 0. The next A is treated as a first beat on slot 0.
